// File: rtl/bram_copy_engine_if.sv
// Command and BRAM-port bundle for bram_copy_engine.
// The slave modport is the engine's view; the master modport is the host and BRAM side.
interface bram_copy_engine_if #(
    parameter int data_width    = 8,
    parameter int address_width = 7
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [address_width-1:0] cmd_src;
    logic [address_width-1:0] cmd_dst;
    logic [address_width:0]   cmd_len;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic                     we_a;
    logic [address_width-1:0] add_a;
    logic [data_width-1:0]    data_w_a;
    logic [data_width-1:0]    data_r_a;
    logic                     we_b;
    logic [address_width-1:0] add_b;
    logic [data_width-1:0]    data_w_b;
`ifdef BRAM_COPY_FILL_EN
    logic                     cmd_fill;
    logic [data_width-1:0]    cmd_pattern;

    modport slave (
        input  cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_fill, cmd_pattern, data_r_a,
        output cmd_ready, busy, done, err, we_a, add_a, data_w_a, we_b, add_b, data_w_b
    );
    modport master (
        output cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_fill, cmd_pattern, data_r_a,
        input  cmd_ready, busy, done, err, we_a, add_a, data_w_a, we_b, add_b, data_w_b
    );
`else
    modport slave (
        input  cmd_valid, cmd_src, cmd_dst, cmd_len, data_r_a,
        output cmd_ready, busy, done, err, we_a, add_a, data_w_a, we_b, add_b, data_w_b
    );
    modport master (
        output cmd_valid, cmd_src, cmd_dst, cmd_len, data_r_a,
        input  cmd_ready, busy, done, err, we_a, add_a, data_w_a, we_b, add_b, data_w_b
    );
`endif
endinterface

// File: rtl/bram_copy_engine.sv
// Copies len words through BRAM port A (read) to port B (write) at one word per cycle.
// Optional pattern fill (no port A reads) is enabled by defining BRAM_COPY_FILL_EN.
module bram_copy_engine #(
    parameter int data_width    = 8,
    parameter int address_width = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    bram_copy_engine_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [address_width-1:0] add_a_q, add_a_d;
    logic [address_width-1:0] add_b_q, add_b_d;
    logic [address_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [address_width:0]   rem_q, rem_d;
    logic                     we_b_q, we_b_d;
    logic                     err_q, err_d;

    logic                     fill_q;
    logic [data_width-1:0]    pattern_q;
    logic                     fill_cmd;

    logic                     accept;
    logic [address_width-1:0] delta;
    logic                     hazard;

    assign accept = (state_q == S_IDLE) && bus.cmd_valid;

    // Forward copy is safe unless the destination lands inside the not-yet-read
    // part of the source; delta==1 is covered by the BRAM's read-first behaviour.
    assign delta  = bus.cmd_dst - bus.cmd_src;
    assign hazard = (delta > address_width'(1)) && ({1'b0, delta} < bus.cmd_len);

`ifdef BRAM_COPY_FILL_EN
    assign fill_cmd = bus.cmd_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q    <= 1'b0;
            pattern_q <= '0;
        end else if (accept) begin
            fill_q    <= bus.cmd_fill;
            pattern_q <= bus.cmd_pattern;
        end
    end
`else
    assign fill_cmd  = 1'b0;
    assign fill_q    = 1'b0;
    assign pattern_q = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            add_a_q  <= '0;
            add_b_q  <= '0;
            wr_ptr_q <= '0;
            rem_q    <= '0;
            we_b_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            wr_ptr_q <= wr_ptr_d;
            rem_q    <= rem_d;
            we_b_q   <= we_b_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        wr_ptr_d = wr_ptr_q;
        rem_d    = rem_q;
        we_b_d   = 1'b0;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    add_a_d  = bus.cmd_src;
                    wr_ptr_d = bus.cmd_dst;
                    rem_d    = bus.cmd_len;
                    err_d    = 1'b0;
                    if (bus.cmd_len == '0) begin
                        state_d = S_DONE;
                    end else if (fill_cmd) begin
                        // Fill writes start on the very next cycle, so issue the first one here.
                        state_d  = S_FILL;
                        we_b_d   = 1'b1;
                        add_b_d  = bus.cmd_dst;
                        wr_ptr_d = bus.cmd_dst + address_width'(1);
                    end else if (hazard) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            // Each read issued now returns next cycle; the matching write is
            // registered so it appears alongside that returned data.
            S_RUN: begin
                we_b_d   = 1'b1;
                add_b_d  = wr_ptr_q;
                wr_ptr_d = wr_ptr_q + address_width'(1);
                add_a_d  = add_a_q + address_width'(1);
                rem_d    = rem_q - 1'b1;
                if (rem_q == (address_width + 1)'(1)) begin
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                state_d = S_DONE;
            end

            S_FILL: begin
                rem_d = rem_q - 1'b1;
                if (rem_q == (address_width + 1)'(1)) begin
                    state_d = S_DONE;
                end else begin
                    we_b_d   = 1'b1;
                    add_b_d  = wr_ptr_q;
                    wr_ptr_d = wr_ptr_q + address_width'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_FILL);
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = (state_q == S_DONE) && err_q;

    assign bus.we_a      = 1'b0;
    assign bus.data_w_a  = '0;
    assign bus.add_a     = add_a_q;

    // Copy data is forwarded straight from port A so it lines up with the registered write strobe.
    assign bus.we_b      = we_b_q;
    assign bus.add_b     = add_b_q;
    assign bus.data_w_b  = we_b_q ? (fill_q ? pattern_q : bus.data_r_a) : '0;

endmodule

// File: tb/tb_bram_copy_engine.sv
// Randomized scoreboard bench for bram_copy_engine with a behavioural read-first dual-port BRAM.
module tb_bram_copy_engine;
    localparam int DW    = 8;
    localparam int AW    = 7;
    localparam int DEPTH = 1 << AW;
    localparam int BOUND = 400;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_copy_engine_if #(.data_width(DW), .address_width(AW)) bus ();

    bram_copy_engine #(.data_width(DW), .address_width(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural BRAM: port A reads, port B writes, plus a bench-only load port.
    logic [DW-1:0] mem  [DEPTH];
    logic [DW-1:0] gold [DEPTH];
    logic          ld_en   = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    always @(posedge clk) begin
        bus.data_r_a <= mem[bus.add_a];
        if (bus.we_b) mem[bus.add_b] <= bus.data_w_b;
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    wr_t  wr_q[$];
    logic done_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and done pulse is matched against the next expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.we_b) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got add_b=0x%0h data=0x%0h, expected no write",
                             bus.add_b, bus.data_w_b);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("write_addr", 32'(bus.add_b), 32'(w.addr));
                    chk("write_data", 32'(bus.data_w_b), 32'(w.data));
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 err=%0d, expected no done", bus.err);
                end else begin
                    logic e;
                    e = done_q.pop_front();
                    chk("done_err", 32'(bus.err), 32'(e));
                end
            end
        end
    end

    task automatic load(input int addr, input logic [DW-1:0] data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = AW'(addr);
        ld_data = data;
        gold[addr] = data;
    endtask

    task automatic drive_cmd(input int src, input int dst, input int len,
                             input bit fill, input logic [DW-1:0] pat);
        bus.cmd_src = AW'(src);
        bus.cmd_dst = AW'(dst);
        bus.cmd_len = (AW + 1)'(len);
`ifdef BRAM_COPY_FILL_EN
        bus.cmd_fill    = fill;
        bus.cmd_pattern = pat;
`endif
    endtask

    // Reference: a copy behaves as a snapshot of the source range; a fill writes the pattern.
    task automatic run_cmd(input int src, input int dst, input int len,
                           input bit fill, input logic [DW-1:0] pat);
        int            delta, lat, cyc;
        bit            hz;
        logic [DW-1:0] snap[$];
        wr_t           w;
        delta = (dst - src) & (DEPTH - 1);
        hz    = !fill && (delta >= 2) && (delta < len);
        if (len == 0 || hz) lat = 1;
        else if (fill)      lat = len + 1;
        else                lat = len + 2;
        if (!hz) begin
            for (int i = 0; i < len; i++)
                snap.push_back(fill ? pat : gold[(src + i) % DEPTH]);
            for (int i = 0; i < len; i++) begin
                w.addr = AW'((dst + i) % DEPTH);
                w.data = snap[i];
                wr_q.push_back(w);
                gold[w.addr] = w.data;
            end
        end
        done_q.push_back(hz);

        @(negedge clk);
        cyc = 0;
        while (!bus.cmd_ready && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        drive_cmd(src, dst, len, fill, pat);
        @(negedge clk);
        // Junk command held valid while busy must be ignored.
        drive_cmd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                  $urandom_range(1, 8), 1'b0, DW'($urandom));
        cyc = 1;
        if (lat > 1) chk("busy_cycle1", 32'(bus.busy), 32'd1);
        while (!bus.done && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        chk("done_latency", 32'(cyc), 32'(lat));
        @(negedge clk);
        chk("ready_after_done", 32'(bus.cmd_ready), 32'd1);
        $display("cmd src=0x%02h dst=0x%02h len=%0d fill=%0d expect_err=%0d cycles=%0d",
                 src, dst, len, fill, hz, cyc);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
        chk({tag, "_done"},      32'(bus.done),      32'd0);
        chk({tag, "_err"},       32'(bus.err),       32'd0);
        chk({tag, "_we_b"},      32'(bus.we_b),      32'd0);
        chk({tag, "_add_a"},     32'(bus.add_a),     32'd0);
        chk({tag, "_add_b"},     32'(bus.add_b),     32'd0);
        chk({tag, "_data_w_b"},  32'(bus.data_w_b),  32'd0);
    endtask

    initial begin
        int src, dst, len, r;
        bus.cmd_valid = 1'b0;
        drive_cmd(0, 0, 0, 1'b0, '0);

        #12;
        chk_reset_outputs("reset");
        chk("reset_we_a", 32'(bus.we_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) load(i, DW'($urandom));
        for (int i = 0; i < 4; i++) load(16 + i, DW'(8'hA0 + i));
        @(negedge clk);
        ld_en = 1'b0;

        // Directed cases
        run_cmd(16'h10, 16'h40, 4, 1'b0, '0);
        for (int i = 0; i < 4; i++) chk("plan_copy_mem", 32'(mem[8'h40 + i]), 32'(8'hA0 + i));
        run_cmd(16'h05, 16'h20, 0, 1'b0, '0);
        run_cmd(16'h7E, 16'h00, 4, 1'b0, '0);
        run_cmd(16'h10, 16'h12, 4, 1'b0, '0);
        run_cmd(16'h10, 16'h11, 4, 1'b0, '0);
        run_cmd(16'h10, 16'h13, 3, 1'b0, '0);
        run_cmd(16'h33, 16'h34, DEPTH, 1'b0, '0);
        run_cmd(16'h50, 16'h50, DEPTH, 1'b0, '0);
        run_cmd(16'h20, 16'h25, DEPTH, 1'b0, '0);

        // Reset two cycles into an 8-word copy: only the first write survives.
        begin
            wr_t w;
            w.addr = AW'(8'h40);
            w.data = gold[8'h10];
            wr_q.push_back(w);
            gold[8'h40] = w.data;
            @(negedge clk);
            bus.cmd_valid = 1'b1;
            drive_cmd(16'h10, 16'h40, 8, 1'b0, '0);
            @(posedge clk);
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #1 rst_n = 1'b0;
            #1 chk_reset_outputs("midreset");
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (12) @(negedge clk);
            chk("midreset_idle", 32'(bus.cmd_ready), 32'd1);
            $display("cmd src=0x10 dst=0x40 len=8 aborted by reset");
        end

`ifdef BRAM_COPY_FILL_EN
        run_cmd(16'h00, 16'h7F, 3, 1'b1, 8'h5A);
        chk("plan_fill_7f", 32'(mem[127]), 32'h5A);
        chk("plan_fill_00", 32'(mem[0]),   32'h5A);
        chk("plan_fill_01", 32'(mem[1]),   32'h5A);
        run_cmd(16'h10, 16'h12, 5, 1'b1, 8'hC3);
`endif

        // Randomized commands
        for (int n = 0; n < 30; n++) begin
            r   = $urandom_range(0, 9);
            src = $urandom_range(0, DEPTH - 1);
            if (r == 0) begin
                len = 0;
                dst = $urandom_range(0, DEPTH - 1);
            end else if (r == 1) begin
                len = DEPTH;
                dst = (src + $urandom_range(0, 3)) % DEPTH;
            end else begin
                len = $urandom_range(1, 20);
                dst = (r < 5) ? (src + $urandom_range(0, 6)) % DEPTH : $urandom_range(0, DEPTH - 1);
            end
`ifdef BRAM_COPY_FILL_EN
            run_cmd(src, dst, len, ($urandom_range(0, 3) == 0), DW'($urandom));
`else
            run_cmd(src, dst, len, 1'b0, '0);
`endif
        end

        repeat (4) @(negedge clk);
        chk("pending_writes", 32'(wr_q.size()), 32'd0);
        chk("pending_dones", 32'(done_q.size()), 32'd0);
        for (int i = 0; i < DEPTH; i++) chk("final_mem", 32'(mem[i]), 32'(gold[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
